// File: rtl/uart_hex_formatter_pkg.sv
// Shared definitions for the UART hex formatter and its FIFO.
// Holds the FSM state encoding, the ASCII constants and the nibble-to-ASCII helper.
package uart_hex_formatter_pkg;

    // FSM states, 3-bit encoding; the value is exported on dbg_state
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_LO   = 3'd2,
        ST_SEP  = 3'd3,
        ST_LF   = 3'd4,
        ST_CR   = 3'd5
    } fmt_state_e;

    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A_UC = 8'h41;
    localparam logic [7:0] ASCII_A_LC = 8'h61;

    // Map a 4-bit nibble to its ASCII hex digit; upper selects A-F versus a-f
    function automatic logic [7:0] hex_char(input logic [3:0] n, input logic upper);
        logic [7:0] base;
        if (n < 4'd10) begin
            return ASCII_0 + {4'h0, n};
        end
        base = upper ? ASCII_A_UC : ASCII_A_LC;
        return base + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_hex_formatter_sync_fifo.sv
// Single-clock FIFO with full/empty flags and a show-ahead read port:
// rd_data always presents the oldest entry, rd_en retires it.
// Writes while full and reads while empty are ignored.
module uart_hex_formatter_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; full/empty are taken from the pre-edge pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_hex_formatter.sv
// Buffers 8-bit samples and streams each as two ASCII hex digits plus a separator,
// ending every VALS_PER_LINE values with LF, CR instead of the separator.
//
// Byte handshake: tx_data/tx_valid are registered; a byte moves when tx_valid and
// tx_ready are both high at a rising edge. While tx_valid=1 and tx_ready=0 neither
// tx_valid nor tx_data changes.
module uart_hex_formatter
    import uart_hex_formatter_pkg::*;
#(
    parameter int         FIFO_DEPTH    = 16,
    parameter int         VALS_PER_LINE = 16,
    parameter logic [7:0] SEP_CHAR      = 8'h20,
    parameter bit         UPPERCASE     = 1'b1
) (
    input  logic       uart_clk,
    input  logic       uart_rst,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       pix_drop,
    input  logic       fmt_en,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       line_done,
    output logic [2:0] dbg_state
);

    localparam int                 CNT_W    = (VALS_PER_LINE > 1) ? $clog2(VALS_PER_LINE) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(VALS_PER_LINE - 1);

    fmt_state_e       state_q, state_d;
    logic [3:0]       lo_nib_q, lo_nib_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             line_done_q, line_done_d;
    logic             pix_drop_q;

    logic             fifo_pop;
    logic [7:0]       fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic             xfer;

    uart_hex_formatter_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (uart_clk),
        .rst     (uart_rst),
        .wr_en   (pix_valid),
        .wr_data (pix_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign xfer = tx_valid_q && tx_ready;

    // Next-state and next-output logic; the output registers are loaded with the
    // byte belonging to the state being entered so they are valid on entry.
    // Only the low nibble is kept: the high nibble goes straight to tx_data on pop.
    always_comb begin
        state_d     = state_q;
        lo_nib_d    = lo_nib_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        line_done_d = 1'b0;
        fifo_pop    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (fmt_en && !fifo_empty) begin
                    fifo_pop   = 1'b1;
                    lo_nib_d   = fifo_rd_data[3:0];
                    tx_data_d  = hex_char(fifo_rd_data[7:4], UPPERCASE);
                    tx_valid_d = 1'b1;
                    state_d    = ST_HI;
                end
            end
            ST_HI: begin
                if (xfer) begin
                    tx_data_d = hex_char(lo_nib_q, UPPERCASE);
                    state_d   = ST_LO;
                end
            end
            ST_LO: begin
                if (xfer) begin
                    if (cnt_q == CNT_LAST) begin
                        tx_data_d = ASCII_LF;
                        state_d   = ST_LF;
                    end else begin
                        cnt_d     = cnt_q + CNT_W'(1);
                        tx_data_d = SEP_CHAR;
                        state_d   = ST_SEP;
                    end
                end
            end
            ST_SEP: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_LF: begin
                if (xfer) begin
                    tx_data_d = ASCII_CR;
                    state_d   = ST_CR;
                end
            end
            ST_CR: begin
                if (xfer) begin
                    cnt_d       = '0;
                    line_done_d = 1'b1;
                    tx_valid_d  = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State, value, line counter and output registers; reset abandons any partial line
    always_ff @(posedge uart_clk) begin
        if (uart_rst) begin
            state_q     <= ST_IDLE;
            lo_nib_q    <= '0;
            cnt_q       <= '0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_nib_q    <= lo_nib_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            line_done_q <= line_done_d;
        end
    end

    // Drop pulse: a sample offered while the FIFO was full before this edge is lost
    always_ff @(posedge uart_clk) begin
        if (uart_rst) begin
            pix_drop_q <= 1'b0;
        end else begin
            pix_drop_q <= pix_valid && fifo_full;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign line_done = line_done_q;
    assign pix_drop  = pix_drop_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_hex_formatter.sv
// Bench for uart_hex_formatter: three instances with different line lengths and
// digit cases share one stimulus stream; a queue-based model predicts each byte.
module tb_uart_hex_formatter;

    localparam int NI    = 3;
    localparam int DEPTH = 16;
    localparam int VPL_T [NI] = '{2, 1, 3};
    localparam bit UP_T  [NI] = '{1'b1, 1'b0, 1'b0};

    logic       uart_clk;
    logic       uart_rst;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       fmt_en;
    logic       tx_ready;
    logic       pix_drop  [NI];
    logic [7:0] tx_data   [NI];
    logic       tx_valid  [NI];
    logic       line_done [NI];
    logic [2:0] dbg_state [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_hex_formatter #(
            .FIFO_DEPTH    (DEPTH),
            .VALS_PER_LINE (VPL_T[g]),
            .SEP_CHAR      (8'h20),
            .UPPERCASE     (UP_T[g])
        ) u_dut (
            .uart_clk  (uart_clk),
            .uart_rst  (uart_rst),
            .pix_valid (pix_valid),
            .pix_data  (pix_data),
            .pix_drop  (pix_drop[g]),
            .fmt_en    (fmt_en),
            .tx_data   (tx_data[g]),
            .tx_valid  (tx_valid[g]),
            .tx_ready  (tx_ready),
            .line_done (line_done[g]),
            .dbg_state (dbg_state[g])
        );
    end

    // ---------------- clock ----------------
    initial uart_clk = 1'b0;
    always #5 uart_clk = ~uart_clk;

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic [7:0] exp_q [$];
    logic [7:0] mq    [NI][$];   // model FIFO contents
    logic [7:0] eb    [NI][$];   // bytes still owed for the value in flight
    logic [7:0] log_q [NI][$];   // every byte the DUT handed over
    bit         busy   [NI];
    int         vcnt   [NI];
    bit         drop_e [NI];
    bit         ld_e   [NI];
    int         drops_act [NI];
    int         lds_act   [NI];
    int         base    [NI];
    int         dr_base [NI];
    int         ld_base [NI];

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", name, g, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_hex(input int n, input bit up);
        string digits;
        digits = up ? "0123456789ABCDEF" : "0123456789abcdef";
        return digits[n];
    endfunction

    // ---------------- model: advances on each rising edge with pre-edge values ----------------
    always @(posedge uart_clk) begin
        bit         full_now;
        bit         busy_then;
        logic [7:0] b;
        logic [7:0] v;
        for (int g = 0; g < NI; g++) begin
            if (uart_rst) begin
                mq[g].delete();
                eb[g].delete();
                busy[g]   = 1'b0;
                vcnt[g]   = 0;
                drop_e[g] = 1'b0;
                ld_e[g]   = 1'b0;
            end else begin
                full_now  = (mq[g].size() == DEPTH);
                busy_then = busy[g];
                drop_e[g] = pix_valid && full_now;
                ld_e[g]   = 1'b0;
                if (tx_valid[g] && tx_ready) begin
                    log_q[g].push_back(tx_data[g]);
                    chk("xfer_expected", g, 32'(eb[g].size() != 0), 32'd1);
                    if (eb[g].size() != 0) begin
                        b = eb[g].pop_front();
                        if (eb[g].size() == 0) begin
                            busy[g] = 1'b0;
                            if (b == 8'h0D) ld_e[g] = 1'b1;
                        end
                    end
                end
                if (!busy_then && fmt_en && mq[g].size() != 0) begin
                    v = mq[g].pop_front();
                    eb[g].push_back(m_hex(int'(v) / 16, UP_T[g]));
                    eb[g].push_back(m_hex(int'(v) % 16, UP_T[g]));
                    if (vcnt[g] == VPL_T[g] - 1) begin
                        eb[g].push_back(8'h0A);
                        eb[g].push_back(8'h0D);
                        vcnt[g] = 0;
                    end else begin
                        eb[g].push_back(8'h20);
                        vcnt[g]++;
                    end
                    busy[g] = 1'b1;
                end
                if (pix_valid && !full_now) mq[g].push_back(pix_data);
            end
        end
    end

    // ---------------- compare: every falling edge ----------------
    always @(negedge uart_clk) begin
        for (int g = 0; g < NI; g++) begin
            if (pix_drop[g])  drops_act[g]++;
            if (line_done[g]) lds_act[g]++;
            if (chk_en) begin
                chk("tx_valid", g, 32'(tx_valid[g]), 32'(busy[g]));
                if (busy[g] && eb[g].size() != 0)
                    chk("tx_data", g, 32'(tx_data[g]), 32'(eb[g][0]));
                chk("pix_drop", g, 32'(pix_drop[g]), 32'(drop_e[g]));
                chk("line_done", g, 32'(line_done[g]), 32'(ld_e[g]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge uart_clk);
    endtask

    task automatic strobe(input logic [7:0] v);
        pix_valid = 1'b1;
        pix_data  = v;
        @(negedge uart_clk);
        pix_valid = 1'b0;
    endtask

    task automatic do_reset();
        uart_rst = 1'b1;
        @(negedge uart_clk);
        uart_rst = 1'b0;
    endtask

    task automatic snap();
        for (int g = 0; g < NI; g++) begin
            base[g]    = log_q[g].size();
            dr_base[g] = drops_act[g];
            ld_base[g] = lds_act[g];
        end
        exp_q.delete();
    endtask

    task automatic wait_idle(input int budget);
        int k;
        bit act;
        k   = 0;
        act = 1'b1;
        while (act && k < budget) begin
            act = 1'b0;
            for (int g = 0; g < NI; g++)
                if (busy[g] || mq[g].size() != 0) act = 1'b1;
            if (act) begin
                @(negedge uart_clk);
                k++;
            end
        end
        chk("drain_in_budget", 0, 32'(!act), 32'd1);
    endtask

    task automatic chk_log(input string name, input int g);
        int n;
        n = log_q[g].size() - base[g];
        chk({name, "_len"}, g, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            chk(name, g, 32'(log_q[g][base[g] + i]), 32'(exp_q[i]));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        string hexs;
        uart_rst  = 1'b1;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        fmt_en    = 1'b1;
        tx_ready  = 1'b1;
        cyc(2);
        for (int g = 0; g < NI; g++) begin
            chk("rst_tx_valid", g, 32'(tx_valid[g]), 32'd0);
            chk("rst_tx_data", g, 32'(tx_data[g]), 32'h00);
            chk("rst_pix_drop", g, 32'(pix_drop[g]), 32'd0);
            chk("rst_line_done", g, 32'(line_done[g]), 32'd0);
        end
        chk_en   = 1'b1;
        uart_rst = 1'b0;
        cyc(1);

        // 1: single value, latency of two cycles from the strobe
        snap();
        strobe(8'hA5);
        chk("lat_cycle1_valid", 0, 32'(tx_valid[0]), 32'd0);
        cyc(1);
        chk("lat_cycle2_valid", 0, 32'(tx_valid[0]), 32'd1);
        chk("lat_cycle2_data", 0, 32'(tx_data[0]), 32'h41);
        wait_idle(50);
        exp_q = '{8'h41, 8'h35, 8'h20};
        chk_log("t1_bytes", 0);
        exp_q = '{8'h61, 8'h35, 8'h0A, 8'h0D};
        chk_log("t1_bytes", 1);

        // 2: line end after two values, counter restarts
        do_reset();
        snap();
        strobe(8'h00);
        strobe(8'hFF);
        strobe(8'h12);
        wait_idle(100);
        exp_q = '{8'h30, 8'h30, 8'h20, 8'h46, 8'h46, 8'h0A, 8'h0D, 8'h31, 8'h32, 8'h20};
        chk_log("t2_bytes", 0);
        chk("t2_line_done_cnt", 0, 32'(lds_act[0] - ld_base[0]), 32'd1);
        exp_q = '{8'h30, 8'h30, 8'h20, 8'h66, 8'h66, 8'h20, 8'h31, 8'h32, 8'h0A, 8'h0D};
        chk_log("t2_bytes", 2);
        chk("t2_line_done_cnt", 2, 32'(lds_act[2] - ld_base[2]), 32'd1);

        // 3: back-pressure during HI
        do_reset();
        snap();
        tx_ready = 1'b0;
        strobe(8'h3C);
        cyc(1);
        cyc(10);
        chk("t3_hold_valid", 0, 32'(tx_valid[0]), 32'd1);
        chk("t3_hold_data", 0, 32'(tx_data[0]), 32'h33);
        tx_ready = 1'b1;
        wait_idle(50);
        exp_q = '{8'h33, 8'h43, 8'h20};
        chk_log("t3_bytes", 0);

        // 4: overflow with formatting stalled, then drain in order
        do_reset();
        snap();
        tx_ready = 1'b0;
        fmt_en   = 1'b0;
        for (int k = 0; k < 17; k++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(k * 17);
            @(negedge uart_clk);
        end
        pix_valid = 1'b0;
        cyc(2);
        chk("t4_drop_cnt", 0, 32'(drops_act[0] - dr_base[0]), 32'd1);
        fmt_en   = 1'b1;
        tx_ready = 1'b1;
        wait_idle(400);
        hexs = "0123456789ABCDEF";
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(hexs[k]);
            exp_q.push_back(hexs[k]);
            if (k % 2 == 0) begin
                exp_q.push_back(8'h20);
            end else begin
                exp_q.push_back(8'h0A);
                exp_q.push_back(8'h0D);
            end
        end
        chk_log("t4_bytes", 0);
        chk("t4_line_done_cnt", 0, 32'(lds_act[0] - ld_base[0]), 32'd8);

        // 5: reset while in LO with a value still queued
        do_reset();
        snap();
        strobe(8'h11);
        wait_idle(50);
        strobe(8'h22);
        strobe(8'h44);
        cyc(1);
        chk("t5_pre_rst_lo", 0, 32'(tx_data[0]), 32'h32);
        uart_rst = 1'b1;
        cyc(1);
        uart_rst = 1'b0;
        chk("t5_post_rst_valid", 0, 32'(tx_valid[0]), 32'd0);
        cyc(4);
        chk("t5_fifo_flushed", 0, 32'(tx_valid[0]), 32'd0);
        strobe(8'h55);
        wait_idle(50);
        exp_q = '{8'h31, 8'h31, 8'h20, 8'h32, 8'h35, 8'h35, 8'h20};
        chk_log("t5_bytes", 0);

        // 6: lowercase digits, enable dropped while in HI
        do_reset();
        snap();
        strobe(8'hBC);
        strobe(8'hDE);
        fmt_en = 1'b0;
        cyc(20);
        chk("t6_no_pop", 2, 32'(tx_valid[2]), 32'd0);
        exp_q = '{8'h62, 8'h63, 8'h20};
        chk_log("t6_bytes", 2);
        exp_q = '{8'h62, 8'h63, 8'h0A, 8'h0D};
        chk_log("t6_bytes", 1);
        fmt_en = 1'b1;
        wait_idle(50);
        exp_q = '{8'h62, 8'h63, 8'h20, 8'h64, 8'h65, 8'h20};
        chk_log("t6_resume", 2);

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
